overlay_peak_ctrl: RTL
======================

OVERLAY_PEAK_CTRL -- requirements
Module: overlay_peak_ctrl

Interface
REQ-001 SHALL have parameter GRID_U, default 32, number of valid peak columns (20-px cells across 640).
REQ-002 SHALL have parameter GRID_V, default 32, number of valid peak rows (15-px cells across 480).
REQ-003 SHALL have parameter SCORE_MIN, default 16'h0100, minimum score for a candidate to qualify.
REQ-004 SHALL have parameter TIMEOUT_FRAMES, default 8 (range 1..15), consecutive missed frames before track loss.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse, issued in vertical blanking, that marks the frame boundary.
REQ-008 SHALL have port freeze  input  1  hold the current overlay; no commits and no miss counting.
REQ-009 SHALL have port cand_valid  input  1  detector candidate present.
REQ-010 SHALL have port cand_ready  output  1  controller accepts the candidate.
REQ-011 SHALL have port cand_u  input  5  candidate column index.
REQ-012 SHALL have port cand_v  input  5  candidate row index.
REQ-013 SHALL have port cand_score  input  16  candidate score, unsigned.
REQ-014 SHALL have port peak_u  output  5  registered column index driven to the overlay.
REQ-015 SHALL have port peak_v  output  5  registered row index driven to the overlay.
REQ-016 SHALL have port marker_en  output  1  overlay marker enable.
REQ-017 SHALL have port track_state  output  2  encoding: 0 SEARCH, 1 TRACK, 2 COAST.
REQ-018 SHALL have port miss_cnt  output  4  count of consecutive frames without a qualifying candidate.

Function
REQ-019 cand_ready SHALL equal !freeze; reset forces cand_ready to 0 (driven combinationally from rst).
REQ-020 A candidate is accepted when cand_valid && cand_ready on a rising clk edge.
REQ-021 An accepted candidate SHALL qualify only if cand_score >= SCORE_MIN, cand_u < GRID_U and cand_v < GRID_V; non-qualifying candidates SHALL be silently dropped.
REQ-022 Shadow registers (sh_valid, sh_u, sh_v, sh_score) SHALL hold the best qualifying candidate of the current frame.
REQ-023 A qualifying candidate SHALL replace the shadow if sh_valid==0 or its score is strictly greater than sh_score; on equal scores the earlier candidate SHALL be kept.
REQ-024 On frame_start, the shadow SHALL be cleared (sh_valid=0) in the same edge as the commit.
REQ-025 A candidate accepted on the same edge as frame_start SHALL belong to the new frame: it is evaluated against the cleared shadow, not committed.
REQ-026 On frame_start with freeze=0 and sh_valid=1: peak_u/peak_v SHALL load sh_u/sh_v, miss_cnt SHALL become 0, and state SHALL become TRACK.
REQ-027 On frame_start with freeze=0 and sh_valid=0: miss_cnt SHALL increment, saturating at 15.
REQ-028 In the case of REQ-027, a TRACK state SHALL move to COAST if the new miss_cnt < TIMEOUT_FRAMES.
REQ-029 In the case of REQ-027, TRACK or COAST SHALL move to SEARCH when the new miss_cnt >= TIMEOUT_FRAMES.
REQ-030 In the case of REQ-027, a SEARCH state SHALL remain in SEARCH.
REQ-031 In the case of REQ-027, peak_u and peak_v SHALL be held.
REQ-032 On frame_start with freeze=1, outputs, state and miss_cnt SHALL be held, and the shadow SHALL still be cleared.
REQ-033 marker_en SHALL be a registered 1 in TRACK or COAST and 0 in SEARCH, updating on the same edge as the state register.
REQ-034 Latency SHALL be: outputs change on the clk edge that samples frame_start; no output changes at any other time except under reset.
REQ-035 track_state encoding 3 SHALL be unreachable; if entered, the next edge SHALL move the block to SEARCH.

Reset
REQ-036 While rst=1: peak_u=0, peak_v=0, marker_en=0, track_state=SEARCH, miss_cnt=0, sh_valid=0, cand_ready=0.
REQ-037 Reset asserted mid-frame SHALL discard the shadow; the first frame_start after release SHALL count as a miss.

Verification
REQ-038 Scenario: reset release; candidates (3,4,score 0x0200) then (7,9,score 0x0300); frame_start -> next cycle peak_u=7, peak_v=9, marker_en=1, track_state=1, miss_cnt=0.
REQ-039 Scenario: equal scores (2,2,0x0400) then (5,5,0x0400); frame_start -> peak=(2,2). Score 0x00FF alone -> dropped; miss_cnt increments.
REQ-040 Scenario: from TRACK, 8 frame_starts with no candidates -> COAST with miss_cnt 1..7 and marker_en=1; at the 8th, track_state=0 and marker_en=0; peak_u/peak_v held throughout.
REQ-041 Scenario: candidate (10,10,0x0500) accepted on the same cycle as frame_start -> not committed at that frame; committed at the following frame_start.
REQ-042 Scenario: freeze=1 -> cand_ready=0; frame_start leaves outputs and miss_cnt unchanged; after freeze falls, the next frame_start with no candidates counts as a miss.
REQ-043 Scenario: rst pulsed mid-frame after a qualifying candidate -> all outputs are 0 immediately (asynchronous); the next frame_start gives miss_cnt=1 and track_state=SEARCH.

Source files
------------

// File: rtl/overlay_peak_if.sv
// Detector/overlay bus for overlay_peak_ctrl.
//   frame_start : frame boundary pulse (vertical blanking)
//   freeze      : hold overlay, no commits, no miss counting
//   cand_*      : candidate handshake (valid/ready) with column, row and score
//   peak_*      : registered overlay position
//   marker_en   : overlay marker enable
//   track_state : 0 SEARCH, 1 TRACK, 2 COAST
//   miss_cnt    : consecutive frames without a qualifying candidate
// The master modport is the detector/overlay side; slave is the controller.
interface overlay_peak_if;
  logic        frame_start;
  logic        freeze;
  logic        cand_valid;
  logic        cand_ready;
  logic [4:0]  cand_u;
  logic [4:0]  cand_v;
  logic [15:0] cand_score;
  logic [4:0]  peak_u;
  logic [4:0]  peak_v;
  logic        marker_en;
  logic [1:0]  track_state;
  logic [3:0]  miss_cnt;

  modport master (
    output frame_start, freeze, cand_valid, cand_u, cand_v, cand_score,
    input  cand_ready, peak_u, peak_v, marker_en, track_state, miss_cnt
  );
  modport slave (
    input  frame_start, freeze, cand_valid, cand_u, cand_v, cand_score,
    output cand_ready, peak_u, peak_v, marker_en, track_state, miss_cnt
  );
endinterface

// File: rtl/overlay_peak_ctrl.sv
// Overlay peak tracker. Keeps the best qualifying candidate of the current
// frame in a shadow, commits it to the overlay at frame_start and runs a
// SEARCH/TRACK/COAST tracker with a saturating miss counter.
//   clk  : single clock
//   rst  : asynchronous active-high reset
//   bus  : overlay_peak_if.slave (candidate handshake, frame control, overlay outputs)
module overlay_peak_ctrl #(
  parameter int          GRID_U         = 32,
  parameter int          GRID_V         = 32,
  parameter logic [15:0] SCORE_MIN      = 16'h0100,
  parameter int          TIMEOUT_FRAMES = 8
) (
  input  logic         clk,
  input  logic         rst,
  overlay_peak_if.slave bus
);
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_COAST  = 2'd2;
  // 6-bit grid limits so a limit of 32 still compares correctly against 5-bit indices
  localparam logic [5:0] GU_LIM = GRID_U[5:0];
  localparam logic [5:0] GV_LIM = GRID_V[5:0];
  localparam logic [3:0] TO_LIM = TIMEOUT_FRAMES[3:0];

  logic [1:0]  state_q, state_d;
  logic [3:0]  miss_q, miss_d;
  logic [4:0]  pu_q, pu_d, pv_q, pv_d;
  logic        marker_q, marker_d;
  logic        sh_valid_q, sh_valid_d;
  logic [4:0]  sh_u_q, sh_u_d, sh_v_q, sh_v_d;
  logic [15:0] sh_score_q, sh_score_d;

  logic        ready, accept, qualify, base_valid, sh_load, commit;
  logic [3:0]  miss_inc;

  assign ready   = !bus.freeze && !rst;
  assign accept  = bus.cand_valid && ready;
  assign qualify = accept && (bus.cand_score >= SCORE_MIN) &&
                   ({1'b0, bus.cand_u} < GU_LIM) && ({1'b0, bus.cand_v} < GV_LIM);
  assign commit  = bus.frame_start && !bus.freeze;
  assign miss_inc = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;

  // Shadow: a candidate on the frame_start edge belongs to the new frame,
  // so it competes against the cleared shadow. Ties keep the earlier one.
  always_comb begin
    base_valid = bus.frame_start ? 1'b0 : sh_valid_q;
    sh_load    = qualify && (!base_valid || (bus.cand_score > sh_score_q));
    sh_valid_d = base_valid | sh_load;
    sh_u_d     = sh_load ? bus.cand_u     : sh_u_q;
    sh_v_d     = sh_load ? bus.cand_v     : sh_v_q;
    sh_score_d = sh_load ? bus.cand_score : sh_score_q;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      miss_q     <= '0;
      pu_q       <= '0;
      pv_q       <= '0;
      marker_q   <= 1'b0;
      sh_valid_q <= 1'b0;
      sh_u_q     <= '0;
      sh_v_q     <= '0;
      sh_score_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_q     <= miss_d;
      pu_q       <= pu_d;
      pv_q       <= pv_d;
      marker_q   <= marker_d;
      sh_valid_q <= sh_valid_d;
      sh_u_q     <= sh_u_d;
      sh_v_q     <= sh_v_d;
      sh_score_q <= sh_score_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    pu_d    = pu_q;
    pv_d    = pv_q;
    if (state_q == 2'd3) begin
      state_d = ST_SEARCH;          // illegal encoding recovers on any edge
    end else if (commit) begin
      if (sh_valid_q) begin
        state_d = ST_TRACK;
        miss_d  = '0;
        pu_d    = sh_u_q;
        pv_d    = sh_v_q;
      end else begin
        miss_d = miss_inc;
        case (state_q)
          ST_TRACK, ST_COAST: state_d = (miss_inc >= TO_LIM) ? ST_SEARCH : ST_COAST;
          default:            state_d = ST_SEARCH;
        endcase
      end
    end
  end

  // Output logic: marker tracks the next state so it updates with the state register
  always_comb begin
    marker_d = (state_d == ST_TRACK) || (state_d == ST_COAST);
  end

  assign bus.cand_ready  = ready;
  assign bus.peak_u      = pu_q;
  assign bus.peak_v      = pv_q;
  assign bus.marker_en   = marker_q;
  assign bus.track_state = state_q;
  assign bus.miss_cnt    = miss_q;
endmodule
